decode_pipe: RTL and testbench
==============================

# decode_pipe

Registered, parametrised decode/operand-read stage that sits between the fetch and execute stages. It decodes 16-bit instructions, reads register-file operands and resolves operands through N_FWD forwarding sources. It detects load-use hazards and inserts a bubble, resolves conditional jumps on forwarded operands, and latches HALT. All outputs to execute come from a pipeline register with a valid/ready handshake, so execute back-pressure stalls fetch cleanly.

## Interface
- D_SIZE, 32: data width.
- A_SIZE, 10: instruction address width; width of jmp_offset.
- N_FWD, 2: number of forwarding sources; index 0 is the youngest (execute output), higher indices are older.

- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high.
- flush  in  1  squash the output register and drop the input instruction.
- in_instr  in  16  instruction from fetch.
- in_valid  in  1  in_instr is valid.
- in_ready  out  1  stage accepts in_instr this cycle.
- rs_addr1, rs_addr2  out  3 each  register-file read addresses; combinational from in_instr.
- rs_data1, rs_data2  in  D_SIZE each  register-file read data, same cycle.
- fwd_valid  in  N_FWD  forwarding source i holds a register write.
- fwd_dest  in  3*N_FWD  destination register of source i.
- fwd_data  in  D_SIZE*N_FWD  data of source i; not yet valid if fwd_is_load[i].
- fwd_is_load  in  N_FWD  source i is a LOAD whose data is not available yet.
- out_valid  out  1  output register holds an instruction.
- out_ready  in  1  execute consumes the output register.
- alu_en, mem_re, mem_we, loadc_en, reg_we_en, jmp_sel, jmpr_sel  out  1 each  control signals to execute.
- alu_cmd  out  7  instr[15:9].
- dest_reg  out  3  destination register.
- op1, op2  out  D_SIZE each  resolved operands.
- jmp_offset  out  A_SIZE  sign-extended instr[5:0].
- halted  out  1  stage is in HALTED.

## Operation
- Encoding follows the shared opcode header.
  - Class [15:14]=11: ALU, NOP, HALT and shifts.
  - Class 01: JMP, JMPR, JMPcond, JMPRcond; condition code in [11:9].
  - Class 10: STORE, LOAD, LOADC.
  - Field usage per opcode is unchanged from the current read stage.
- Shift immediate: op2 = sign-extended instr[5:0].
- LOADC: op1 = {rs_data1[D_SIZE-1:8], instr[7:0]}.
- Operand resolution per source, applied to the register field actually used by the opcode:
  - Take the lowest index i with fwd_valid[i] && fwd_dest[i]==addr.
  - If no index matches, use rs_data.
  - Immediates are never forwarded.
- Load-use hazard: a used source matches an index i with fwd_is_load[i]. While it holds:
  - in_ready=0.
  - A bubble is written: out_valid=0 once the output register drains.
- Jump conditions are evaluated on the resolved op1 as a signed value: N (<0), NN (>=0), Z (==0), NZ (!=0).
  - A false condition gives jmp_sel=jmpr_sel=0, but the instruction is still issued.
- Unknown opcode: issued as NOP, with all enables 0.
- State machine RUN/HALTED:
  - A HALT accepted in RUN is issued as a NOP-like entry (all enables 0), and the state moves to HALTED.
  - HALTED: in_ready=0. The output register drains normally.
  - Only rst leaves HALTED; flush does not.

## Timing
- Latency: instruction accepted at edge n appears on the outputs after edge n, i.e. one cycle.
- in_ready = RUN && !hazard && (!out_valid || out_ready). Computed combinationally; it does not depend on in_valid.
- Load = in_valid && in_ready.
- Hold: out_valid && !out_ready keeps every output stable.
- Priority order: rst > flush > load > hold.
  - flush: out_valid=0 next cycle, and the current input is not accepted even if in_ready was high.
  - A flush while HALTED clears out_valid and stays HALTED.
- Reset value of every output and register: 0. Exceptions: state=RUN and halted=0; in_ready follows from those.
- Reset mid-stall or mid-hold discards the held instruction.

## Structure
- Opcode, class and condition constants stay in the shared opcode header.
- The state encoding (RUN=0, HALTED=1) is local.
- One sub-module, decode_fwd_mux: an N_FWD-way priority forward mux (addr, rs_data → resolved data, load_hit). It is instantiated twice, once per operand.

## Test plan
- ADD r1←r2,r3 with r2=5, r3=7, no forwarding → next cycle out_valid=1, alu_en=1, reg_we_en=1, op1=5, op2=7, dest_reg=1.
- Source 0 (dest 2, data 9) and source 1 (dest 2, data 4) both valid → op1=9. Source 1 alone valid → op1=4.
- fwd_is_load[0] with dest 3 while ADD uses r3 → in_ready=0 and one bubble (out_valid=0). Load bit cleared → ADD issues with the forwarded value.
- JMPcond N with resolved op1=32'hFFFF_FFFF → jmp_sel=1. With op1=0 → jmp_sel=0, and NN/Z both fire.
- out_ready=0 for 3 cycles with a new in_valid each cycle → outputs stable, in_ready=0, no instruction lost or duplicated.
- HALT then ADD → halted=1 and ADD not accepted. flush keeps halted=1. rst → halted=0 and all outputs 0.

Source files
------------

// File: rtl/decode_pipe_pkg.sv
// Shared opcode header for the decode stage: class, opcode and condition codes
// plus the jump-condition helper.
package decode_pipe_pkg;

  localparam logic [1:0] CLS_JMP = 2'b01;
  localparam logic [1:0] CLS_MEM = 2'b10;
  localparam logic [1:0] CLS_ALU = 2'b11;

  // Class 11 opcodes occupy instr[15:9]; ALU ops use dest[8:6] src[5:3] src[2:0],
  // shifts work in place on [8:6] with a signed immediate in [5:0].
  localparam logic [6:0] OP_NOP  = 7'b1100000;
  localparam logic [6:0] OP_HALT = 7'b1100001;
  localparam logic [6:0] OP_ADD  = 7'b1100010;
  localparam logic [6:0] OP_SUB  = 7'b1100011;
  localparam logic [6:0] OP_AND  = 7'b1100100;
  localparam logic [6:0] OP_OR   = 7'b1100101;
  localparam logic [6:0] OP_XOR  = 7'b1100110;
  localparam logic [6:0] OP_SHL  = 7'b1100111;
  localparam logic [6:0] OP_SHR  = 7'b1101000;

  // Class 01 opcodes occupy instr[15:12], condition in [11:9], register in [8:6]
  // (JMPRcond target in [5:3]), offset in [5:0].
  localparam logic [3:0] OP_JMP   = 4'b0100;
  localparam logic [3:0] OP_JMPR  = 4'b0101;
  localparam logic [3:0] OP_JMPC  = 4'b0110;
  localparam logic [3:0] OP_JMPRC = 4'b0111;

  // Class 10 opcodes occupy instr[15:11]; LOADC uses dest[10:8] and imm[7:0].
  localparam logic [4:0] OP_STORE = 5'b10000;
  localparam logic [4:0] OP_LOAD  = 5'b10001;
  localparam logic [4:0] OP_LOADC = 5'b10010;

  typedef enum logic [2:0] {
    CC_N  = 3'd0,
    CC_NN = 3'd1,
    CC_Z  = 3'd2,
    CC_NZ = 3'd3
  } cond_t;

  // Unknown condition codes never take the jump.
  function automatic logic cond_true(input logic [2:0] cc, input logic neg, input logic zero);
    case (cond_t'(cc))
      CC_N:    return neg;
      CC_NN:   return !neg;
      CC_Z:    return zero;
      CC_NZ:   return !zero;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_fwd_mux.sv
// Priority forward mux: the lowest-index valid source writing addr wins,
// otherwise the register-file value passes through.
module decode_fwd_mux #(
  parameter int D_SIZE = 32,
  parameter int N_FWD  = 2
) (
  input  logic [2:0]              addr,
  input  logic [D_SIZE-1:0]       rs_data,
  input  logic [N_FWD-1:0]        fwd_valid,
  input  logic [3*N_FWD-1:0]      fwd_dest,
  input  logic [D_SIZE*N_FWD-1:0] fwd_data,
  input  logic [N_FWD-1:0]        fwd_is_load,
  output logic [D_SIZE-1:0]       data,
  output logic                    load_hit
);

  always_comb begin
    data     = rs_data;
    load_hit = 1'b0;
    // Walk oldest to youngest so the youngest match is the last write.
    for (int i = N_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_dest[3*i +: 3] == addr)) begin
        data     = fwd_data[D_SIZE*i +: D_SIZE];
        load_hit = fwd_is_load[i];
      end
    end
  end

endmodule

// File: rtl/decode_pipe.sv
// Decode / operand-read stage: decodes 16-bit instructions, resolves operands
// through the forwarding network and registers the result for execute.
module decode_pipe
  import decode_pipe_pkg::*;
#(
  parameter int D_SIZE = 32,
  parameter int A_SIZE = 10,
  parameter int N_FWD  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [15:0]             in_instr,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [2:0]              rs_addr1,
  output logic [2:0]              rs_addr2,
  input  logic [D_SIZE-1:0]       rs_data1,
  input  logic [D_SIZE-1:0]       rs_data2,
  input  logic [N_FWD-1:0]        fwd_valid,
  input  logic [3*N_FWD-1:0]      fwd_dest,
  input  logic [D_SIZE*N_FWD-1:0] fwd_data,
  input  logic [N_FWD-1:0]        fwd_is_load,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    alu_en,
  output logic                    mem_re,
  output logic                    mem_we,
  output logic                    loadc_en,
  output logic                    reg_we_en,
  output logic                    jmp_sel,
  output logic                    jmpr_sel,
  output logic [6:0]              alu_cmd,
  output logic [2:0]              dest_reg,
  output logic [D_SIZE-1:0]       op1,
  output logic [D_SIZE-1:0]       op2,
  output logic [A_SIZE-1:0]       jmp_offset,
  output logic                    halted
);

  // state  | meaning
  // RUN    | accepting instructions from fetch
  // HALTED | HALT issued; fetch blocked until rst, output register still drains
  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;
  state_t state;

  logic d_alu, d_re, d_we, d_lc, d_rw, d_halt;
  logic j_u, jr_u, j_c, jr_c;
  logic use1, use2, imm2, lc_op;
  logic [6:0] d_cmd;
  logic [2:0] d_dest, addr1, addr2;
  logic [D_SIZE-1:0] res1, res2, op1_d, op2_d;
  logic hit1, hit2, hazard, cond_ok, load;

  always_comb begin
    d_alu = 1'b0; d_re = 1'b0; d_we = 1'b0; d_lc = 1'b0; d_rw = 1'b0; d_halt = 1'b0;
    j_u = 1'b0; jr_u = 1'b0; j_c = 1'b0; jr_c = 1'b0;
    use1 = 1'b0; use2 = 1'b0; imm2 = 1'b0; lc_op = 1'b0;
    d_cmd = in_instr[15:9]; d_dest = '0; addr1 = '0; addr2 = '0;
    case (in_instr[15:14])
      CLS_ALU: begin
        case (in_instr[15:9])
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            d_alu = 1'b1; d_rw = 1'b1; d_dest = in_instr[8:6];
            use1 = 1'b1; addr1 = in_instr[5:3];
            use2 = 1'b1; addr2 = in_instr[2:0];
          end
          OP_SHL, OP_SHR: begin
            d_alu = 1'b1; d_rw = 1'b1; d_dest = in_instr[8:6];
            use1 = 1'b1; addr1 = in_instr[8:6]; imm2 = 1'b1;
          end
          OP_NOP:  ;
          OP_HALT: d_halt = 1'b1;
          default: d_cmd = OP_NOP;
        endcase
      end
      CLS_JMP: begin
        case (in_instr[15:12])
          OP_JMP:   j_u = 1'b1;
          OP_JMPR:  begin jr_u = 1'b1; use1 = 1'b1; addr1 = in_instr[8:6]; end
          OP_JMPC:  begin j_c = 1'b1; use1 = 1'b1; addr1 = in_instr[8:6]; end
          OP_JMPRC: begin
            jr_c = 1'b1; use1 = 1'b1; addr1 = in_instr[8:6];
            use2 = 1'b1; addr2 = in_instr[5:3];
          end
          default: d_cmd = OP_NOP;
        endcase
      end
      CLS_MEM: begin
        case (in_instr[15:11])
          OP_STORE: begin
            d_we = 1'b1; use1 = 1'b1; addr1 = in_instr[5:3];
            use2 = 1'b1; addr2 = in_instr[2:0];
          end
          OP_LOAD: begin
            d_re = 1'b1; d_rw = 1'b1; d_dest = in_instr[8:6];
            use1 = 1'b1; addr1 = in_instr[5:3];
          end
          OP_LOADC: begin
            d_lc = 1'b1; d_rw = 1'b1; d_dest = in_instr[10:8];
            use1 = 1'b1; addr1 = in_instr[10:8]; lc_op = 1'b1;
          end
          default: d_cmd = OP_NOP;
        endcase
      end
      default: d_cmd = OP_NOP;
    endcase
  end

  decode_fwd_mux #(.D_SIZE(D_SIZE), .N_FWD(N_FWD)) u_fwd1 (
    .addr(addr1), .rs_data(rs_data1), .fwd_valid(fwd_valid), .fwd_dest(fwd_dest),
    .fwd_data(fwd_data), .fwd_is_load(fwd_is_load), .data(res1), .load_hit(hit1)
  );

  decode_fwd_mux #(.D_SIZE(D_SIZE), .N_FWD(N_FWD)) u_fwd2 (
    .addr(addr2), .rs_data(rs_data2), .fwd_valid(fwd_valid), .fwd_dest(fwd_dest),
    .fwd_data(fwd_data), .fwd_is_load(fwd_is_load), .data(res2), .load_hit(hit2)
  );

  assign rs_addr1 = addr1;
  assign rs_addr2 = addr2;

  // LOADC keeps the upper bits of its destination and replaces the low byte.
  assign op1_d   = !use1 ? '0 : lc_op ? {res1[D_SIZE-1:8], in_instr[7:0]} : res1;
  assign op2_d   = imm2 ? {{(D_SIZE-6){in_instr[5]}}, in_instr[5:0]} : use2 ? res2 : '0;
  assign cond_ok = cond_true(in_instr[11:9], op1_d[D_SIZE-1], op1_d == '0);
  assign hazard  = (use1 && hit1) || (use2 && hit2);

  assign in_ready = (state == RUN) && !hazard && (!out_valid || out_ready);
  assign load     = in_valid && in_ready;
  assign halted   = (state == HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      out_valid <= 1'b0;
      alu_en <= 1'b0; mem_re <= 1'b0; mem_we <= 1'b0; loadc_en <= 1'b0;
      reg_we_en <= 1'b0; jmp_sel <= 1'b0; jmpr_sel <= 1'b0;
      alu_cmd <= '0; dest_reg <= '0; op1 <= '0; op2 <= '0; jmp_offset <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid  <= 1'b1;
      alu_en     <= d_alu;
      mem_re     <= d_re;
      mem_we     <= d_we;
      loadc_en   <= d_lc;
      reg_we_en  <= d_rw;
      jmp_sel    <= j_u || (j_c && cond_ok);
      jmpr_sel   <= jr_u || (jr_c && cond_ok);
      alu_cmd    <= d_cmd;
      dest_reg   <= d_dest;
      op1        <= op1_d;
      op2        <= op2_d;
      jmp_offset <= {{(A_SIZE-6){in_instr[5]}}, in_instr[5:0]};
      if (d_halt) state <= HALTED;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// Directed and randomized bench for decode_pipe against a behavioural
// instruction-level reference model.
module tb_decode_pipe;
  import decode_pipe_pkg::*;

  localparam int D  = 32;
  localparam int A  = 10;
  localparam int NF = 2;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready, in_ready;
  logic [15:0] in_instr;
  logic [2:0] rs_addr1, rs_addr2;
  logic [D-1:0] rs_data1, rs_data2;
  logic [NF-1:0] fwd_valid, fwd_is_load;
  logic [3*NF-1:0] fwd_dest;
  logic [D*NF-1:0] fwd_data;
  logic out_valid, alu_en, mem_re, mem_we, loadc_en, reg_we_en, jmp_sel, jmpr_sel, halted;
  logic [6:0] alu_cmd;
  logic [2:0] dest_reg;
  logic [D-1:0] op1, op2;
  logic [A-1:0] jmp_offset;

  decode_pipe #(.D_SIZE(D), .A_SIZE(A), .N_FWD(NF)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(in_ready), .rs_addr1(rs_addr1), .rs_addr2(rs_addr2),
    .rs_data1(rs_data1), .rs_data2(rs_data2), .fwd_valid(fwd_valid),
    .fwd_dest(fwd_dest), .fwd_data(fwd_data), .fwd_is_load(fwd_is_load),
    .out_valid(out_valid), .out_ready(out_ready), .alu_en(alu_en), .mem_re(mem_re),
    .mem_we(mem_we), .loadc_en(loadc_en), .reg_we_en(reg_we_en), .jmp_sel(jmp_sel),
    .jmpr_sel(jmpr_sel), .alu_cmd(alu_cmd), .dest_reg(dest_reg), .op1(op1), .op2(op2),
    .jmp_offset(jmp_offset), .halted(halted)
  );

  always #5 clk = ~clk;

  // Register file and forwarding sources seen by the stage
  logic [D-1:0] regs [8];
  logic         fv   [NF];
  logic [2:0]   fdst [NF];
  logic [D-1:0] fdat [NF];
  logic         fld  [NF];

  assign rs_data1 = regs[rs_addr1];
  assign rs_data2 = regs[rs_addr2];

  typedef struct {
    logic alu, re, we, lc, rw, js, jrs, hz, halt;
    logic [6:0] cmd;
    logic [2:0] dst;
    logic [D-1:0] o1, o2;
    logic [A-1:0] off;
  } dec_t;

  dec_t exp_o;
  logic exp_valid, exp_halt, m_hz;
  int n_vec = 0, n_err = 0;
  logic [6:0] alu_ops [7];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Architectural register read: youngest pending writer wins; a pending load stalls.
  function automatic logic [D-1:0] rd(input logic [2:0] r);
    for (int i = 0; i < NF; i++)
      if (fv[i] && fdst[i] == r) begin
        if (fld[i]) m_hz = 1'b1;
        return fdat[i];
      end
    return regs[r];
  endfunction

  function automatic dec_t model(input logic [15:0] ins);
    dec_t e;
    int s, v;
    logic [D-1:0] t;
    logic take;
    e = '{default: 0};
    m_hz = 1'b0;
    s = $signed(ins[5:0]);
    e.off = s[A-1:0];
    e.cmd = ins[15:9];
    if (ins[15:14] == 2'b11) begin
      if (ins[15:9] inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR}) begin
        e.alu = 1; e.rw = 1; e.dst = ins[8:6]; e.o1 = rd(ins[5:3]); e.o2 = rd(ins[2:0]);
      end else if (ins[15:9] inside {OP_SHL, OP_SHR}) begin
        e.alu = 1; e.rw = 1; e.dst = ins[8:6]; e.o1 = rd(ins[8:6]); e.o2 = s;
      end else if (ins[15:9] == OP_HALT) e.halt = 1;
      else e.cmd = OP_NOP;
    end else if (ins[15:14] == 2'b01) begin
      if (ins[13:12] != 2'd0) e.o1 = rd(ins[8:6]);
      v = e.o1;
      case (ins[11:9])
        3'd0: take = v < 0;
        3'd1: take = v >= 0;
        3'd2: take = v == 0;
        3'd3: take = v != 0;
        default: take = 0;
      endcase
      case (ins[13:12])
        2'd0: e.js = 1;
        2'd1: e.jrs = 1;
        2'd2: e.js = take;
        default: begin e.o2 = rd(ins[5:3]); e.jrs = take; end
      endcase
    end else if (ins[15:14] == 2'b10) begin
      case (ins[13:11])
        3'd0: begin e.we = 1; e.o1 = rd(ins[5:3]); e.o2 = rd(ins[2:0]); end
        3'd1: begin e.re = 1; e.rw = 1; e.dst = ins[8:6]; e.o1 = rd(ins[5:3]); end
        3'd2: begin
          e.lc = 1; e.rw = 1; e.dst = ins[10:8];
          t = rd(ins[10:8]);
          e.o1 = {t[D-1:8], ins[7:0]};
        end
        default: e.cmd = OP_NOP;
      endcase
    end else e.cmd = OP_NOP;
    e.hz = m_hz;
    return e;
  endfunction

  task automatic drive_fwd();
    for (int i = 0; i < NF; i++) begin
      fwd_valid[i] = fv[i];
      fwd_dest[3*i +: 3] = fdst[i];
      fwd_data[D*i +: D] = fdat[i];
      fwd_is_load[i] = fld[i];
    end
  endtask

  task automatic check_outs(input bit all);
    check("out_valid", 64'(out_valid), 64'(exp_valid));
    check("halted", 64'(halted), 64'(exp_halt));
    if (all || exp_valid) begin
      check("alu_en", 64'(alu_en), 64'(exp_o.alu));
      check("mem_re", 64'(mem_re), 64'(exp_o.re));
      check("mem_we", 64'(mem_we), 64'(exp_o.we));
      check("loadc_en", 64'(loadc_en), 64'(exp_o.lc));
      check("reg_we_en", 64'(reg_we_en), 64'(exp_o.rw));
      check("jmp_sel", 64'(jmp_sel), 64'(exp_o.js));
      check("jmpr_sel", 64'(jmpr_sel), 64'(exp_o.jrs));
      check("alu_cmd", 64'(alu_cmd), 64'(exp_o.cmd));
      check("dest_reg", 64'(dest_reg), 64'(exp_o.dst));
      check("op1", 64'(op1), 64'(exp_o.o1));
      check("op2", 64'(op2), 64'(exp_o.o2));
      check("jmp_offset", 64'(jmp_offset), 64'(exp_o.off));
    end
  endtask

  task automatic do_reset();
    rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_instr = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    exp_valid = 0; exp_halt = 0; exp_o = '{default: 0};
    check_outs(1'b1);
  endtask

  task automatic step(input logic [15:0] ins, input logic iv, input logic ordy, input logic fl);
    dec_t d;
    logic exp_rdy;
    in_instr = ins; in_valid = iv; out_ready = ordy; flush = fl;
    drive_fwd();
    #1;
    d = model(ins);
    exp_rdy = !exp_halt && !d.hz && (!exp_valid || ordy);
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (fl) exp_valid = 0;
    else if (iv && exp_rdy) begin
      exp_o = d; exp_valid = 1;
      if (d.halt) exp_halt = 1;
    end else if (ordy) exp_valid = 0;
    @(negedge clk);
    check_outs(1'b0);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] ins;
    ins = 16'($urandom);
    case ($urandom_range(0, 5))
      0, 1: ins[15:9] = alu_ops[$urandom_range(0, 6)];
      2:    begin ins[15:14] = 2'b01; ins[11:9] = 3'($urandom_range(0, 4)); end
      3:    ins[15:13] = 3'b100;
      default: ;
    endcase
    if (ins[15:9] == OP_HALT) ins[15:9] = OP_NOP;
    return ins;
  endfunction

  localparam logic [15:0] ADD_123 = {OP_ADD, 3'd1, 3'd2, 3'd3};
  localparam logic [15:0] HALT_I  = {OP_HALT, 9'd0};

  logic [15:0] jc;

  initial begin
    alu_ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR};
    for (int i = 0; i < 8; i++) regs[i] = '0;
    for (int i = 0; i < NF; i++) begin fv[i] = 0; fdst[i] = 0; fdat[i] = 0; fld[i] = 0; end
    drive_fwd();
    do_reset();

    // Plain ADD
    regs[2] = 5; regs[3] = 7;
    step(ADD_123, 1, 1, 0);
    check("add_alu_en", 64'(alu_en), 64'd1);
    check("add_reg_we", 64'(reg_we_en), 64'd1);
    check("add_op1", 64'(op1), 64'd5);
    check("add_op2", 64'(op2), 64'd7);
    check("add_dest", 64'(dest_reg), 64'd1);

    // Forward priority: youngest wins, older used alone
    fv[0] = 1; fdst[0] = 2; fdat[0] = 9;
    fv[1] = 1; fdst[1] = 2; fdat[1] = 4;
    step(ADD_123, 1, 1, 0);
    check("fwd_young", 64'(op1), 64'd9);
    fv[0] = 0;
    step(ADD_123, 1, 1, 0);
    check("fwd_old", 64'(op1), 64'd4);
    fv[1] = 0;

    // Load-use bubble, then issue with forwarded value
    fv[0] = 1; fdst[0] = 3; fdat[0] = 32'h55; fld[0] = 1;
    step(ADD_123, 1, 1, 0);
    check("bubble", 64'(out_valid), 64'd0);
    fld[0] = 0;
    step(ADD_123, 1, 1, 0);
    check("fwd_after_load", 64'(op2), 64'h55);
    fv[0] = 0;

    // Conditional jumps
    regs[4] = 32'hFFFF_FFFF;
    jc = {OP_JMPC, 3'(CC_N), 3'd4, 6'd5};
    step(jc, 1, 1, 0);
    check("jn_neg", 64'(jmp_sel), 64'd1);
    check("jmp_off", 64'(jmp_offset), 64'd5);
    regs[4] = 0;
    step(jc, 1, 1, 0);
    check("jn_zero", 64'(jmp_sel), 64'd0);
    check("jn_zero_valid", 64'(out_valid), 64'd1);
    jc = {OP_JMPC, 3'(CC_NN), 3'd4, 6'h3A};
    step(jc, 1, 1, 0);
    check("jnn_zero", 64'(jmp_sel), 64'd1);
    check("jmp_off_neg", 64'(jmp_offset), 64'h3FA);
    jc = {OP_JMPC, 3'(CC_Z), 3'd4, 6'd1};
    step(jc, 1, 1, 0);
    check("jz_zero", 64'(jmp_sel), 64'd1);

    // Back-pressure: three held cycles with new offers each cycle
    step(ADD_123, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step(rand_instr(), 1, 0, 0);
      check("hold_op1", 64'(op1), 64'd5);
    end
    step({OP_SUB, 3'd6, 3'd3, 3'd2}, 1, 1, 0);
    check("after_hold_op1", 64'(op1), 64'd7);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 8; i++) regs[i] = $urandom;
      for (int i = 0; i < NF; i++) begin
        fv[i] = 1'($urandom_range(0, 1));
        fdst[i] = 3'($urandom_range(0, 7));
        fdat[i] = $urandom;
        fld[i] = ($urandom_range(0, 5) == 0);
      end
      step(rand_instr(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < NF; i++) begin fv[i] = 0; fld[i] = 0; end

    // HALT: blocks fetch, survives flush, only rst clears it
    step(HALT_I, 1, 1, 0);
    check("halt_set", 64'(halted), 64'd1);
    step(ADD_123, 1, 0, 0);
    check("halt_blocks", 64'(in_ready), 64'd0);
    step(ADD_123, 1, 1, 1);
    check("halt_flush_valid", 64'(out_valid), 64'd0);
    check("halt_flush_keep", 64'(halted), 64'd1);
    step(ADD_123, 1, 1, 0);

    // Reset while holding a registered entry
    do_reset();
    step(HALT_I, 1, 1, 0);
    step(ADD_123, 1, 0, 0);
    do_reset();
    check("rst_clears_halt", 64'(halted), 64'd0);
    step(ADD_123, 1, 1, 0);
    check("run_after_rst", 64'(out_valid), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
